// File: rtl/rom_streamer.sv
// Host-side streamer for the tinysoc ROM loader: holds a small program image and
// replays it as 6-bit half-words on the target's io_in[7:2] while it comes out of reset.
module rom_streamer #(
  parameter int RST_CYCLES  = 2,
  parameter int INSTR_WIDTH = 12,
  parameter int DEPTH       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [INSTR_WIDTH-1:0]   wr_data,
  input  logic                     start,
  input  logic [3:0]               gpi,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_err,
  output logic                     tgt_rst,
  output logic [INSTR_WIDTH/2-1:0] tgt_data
);

  localparam int HALF  = INSTR_WIDTH / 2;
  localparam int BEATS = 2 * DEPTH;
  localparam int BW    = $clog2(BEATS);
  localparam int CW    = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESET  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic [INSTR_WIDTH-1:0] image_q [DEPTH];
  logic [INSTR_WIDTH-1:0] image_d [DEPTH];
  logic                   tgt_rst_q, tgt_rst_d;
  logic [HALF-1:0]        tgt_data_q, tgt_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   wr_err_q, wr_err_d;

  logic [BW-1:0]          nxt_beat;
  logic [INSTR_WIDTH-1:0] nxt_entry;
  logic                   in_busy;

  assign in_busy   = (state_q == S_RESET) || (state_q == S_STREAM);
  assign nxt_beat  = beat_q + 1'b1;
  assign nxt_entry = image_q[nxt_beat[BW-1:1]];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    image_d    = image_q;
    tgt_rst_d  = tgt_rst_q;
    tgt_data_d = tgt_data_q;
    wr_err_d   = wr_en && in_busy;

    // The image only changes while the target is not being loaded.
    if (wr_en && !in_busy) begin
      image_d[wr_addr] = wr_data;
    end

    case (state_q)
      S_IDLE: begin
        tgt_rst_d  = 1'b1;
        tgt_data_d = '0;
        if (start) begin
          state_d = S_RESET;
          cnt_d   = CW'(RST_CYCLES - 1);
        end
      end
      S_RESET: begin
        tgt_rst_d  = 1'b1;
        tgt_data_d = '0;
        if (cnt_q == '0) begin
          state_d    = S_STREAM;
          tgt_rst_d  = 1'b0;
          tgt_data_d = image_q[0][HALF-1:0];
          beat_d     = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STREAM: begin
        tgt_rst_d = 1'b0;
        if (beat_q == BW'(BEATS - 1)) begin
          state_d    = S_DONE;
          tgt_data_d = {gpi, 2'b00};
        end else begin
          beat_d     = nxt_beat;
          tgt_data_d = nxt_beat[0] ? nxt_entry[INSTR_WIDTH-1:HALF] : nxt_entry[HALF-1:0];
        end
      end
      S_DONE: begin
        tgt_rst_d  = 1'b0;
        tgt_data_d = {gpi, 2'b00};
        // A restart re-resets the target before the full reload.
        if (start) begin
          state_d    = S_RESET;
          cnt_d      = CW'(RST_CYCLES - 1);
          tgt_rst_d  = 1'b1;
          tgt_data_d = '0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tgt_rst_d  = 1'b1;
        tgt_data_d = '0;
      end
    endcase

    busy_d = (state_d == S_RESET) || (state_d == S_STREAM);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      tgt_rst_q  <= 1'b1;
      tgt_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        image_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      beat_q     <= beat_d;
      tgt_rst_q  <= tgt_rst_d;
      tgt_data_q <= tgt_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_err_q   <= wr_err_d;
      image_q    <= image_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign wr_err   = wr_err_q;
  assign tgt_rst  = tgt_rst_q;
  assign tgt_data = tgt_data_q;

endmodule

// File: tb/tb_rom_streamer.sv
// Directed-sequence bench for rom_streamer with random images and gpi values,
// checked against an image array plus a loader model that rebuilds words from beats.
module tb_rom_streamer;

  localparam int RST_CYCLES = 2;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        start = 1'b0;
  logic [3:0]  gpi = '0;
  logic        busy, done, wr_err, tgt_rst;
  logic [5:0]  tgt_data;

  always #5 clk = ~clk;

  rom_streamer #(.RST_CYCLES(RST_CYCLES), .INSTR_WIDTH(12), .DEPTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .gpi      (gpi),
    .busy     (busy),
    .done     (done),
    .wr_err   (wr_err),
    .tgt_rst  (tgt_rst),
    .tgt_data (tgt_data)
  );

  // reference model: the image the host believes is loaded
  logic [11:0] exp_img [8];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_beat(input int b);
    int entry;
    entry = int'(exp_img[b / 2]);
    return (b % 2 == 0) ? 6'(entry % 64) : 6'(entry / 64);
  endfunction

  // driver tasks
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_img(input logic [2:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
    exp_img[a] = d;
    chk("idle_write_no_err", 32'(wr_err), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_tgt_rst"},  32'(tgt_rst),  32'd1);
    chk({tag, "_tgt_data"}, 32'(tgt_data), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_done"},     32'(done),     32'd0);
  endtask

  // Start a load and follow it beat by beat. Optional side actions:
  // with_wr: write together with start; wr_beat: blocked write; start_beat: ignored
  // start; rst_beat: async reset (load is abandoned, returns with rst still low).
  task automatic run_load(input bit with_wr, input int wr_beat, input int start_beat,
                          input int rst_beat);
    logic [5:0]  lo;
    logic [11:0] recon [8];
    logic [2:0]  a;
    logic [11:0] d;
    bit          aborted;
    aborted = 1'b0;
    lo = '0;
    for (int i = 0; i < 8; i++) recon[i] = 'x;
    start = 1'b1;
    if (with_wr) begin
      a = 3'($urandom_range(0, 7));
      d = 12'($urandom);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      exp_img[a] = d;
    end
    cycle();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < RST_CYCLES; c++) begin
      chk("reset_phase_tgt_rst",  32'(tgt_rst),  32'd1);
      chk("reset_phase_tgt_data", 32'(tgt_data), 32'd0);
      chk("reset_phase_busy",     32'(busy),     32'd1);
      chk("reset_phase_done",     32'(done),     32'd0);
      cycle();
    end
    for (int b = 0; b < 16; b++) begin
      if (b == rst_beat) begin
        #3 rst = 1'b0;
        #1;
        check_idle("async_reset");
        chk("async_reset_wr_err", 32'(wr_err), 32'd0);
        aborted = 1'b1;
        break;
      end
      chk("stream_tgt_rst", 32'(tgt_rst), 32'd0);
      chk("stream_busy",    32'(busy),    32'd1);
      chk("stream_done",    32'(done),    32'd0);
      chk("stream_beat",    32'(tgt_data), 32'(exp_beat(b)));
      chk("stream_wr_err",  32'(wr_err), 32'(wr_beat >= 0 && b == wr_beat + 1));
      if (b % 2 == 0) lo = tgt_data;
      else recon[b / 2] = {tgt_data, lo};
      if (b == wr_beat) begin
        wr_en = 1'b1; wr_addr = 3'($urandom_range(0, 7)); wr_data = 12'($urandom);
      end
      if (b == start_beat) start = 1'b1;
      cycle();
      wr_en = 1'b0; start = 1'b0;
    end
    if (!aborted) begin
      chk("end_done",     32'(done),     32'd1);
      chk("end_busy",     32'(busy),     32'd0);
      chk("end_tgt_rst",  32'(tgt_rst),  32'd0);
      chk("end_tgt_data", 32'(tgt_data), 32'({gpi, 2'b00}));
      for (int i = 0; i < 8; i++) begin
        chk("target_rom_word", 32'(recon[i]), 32'(exp_img[i]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) exp_img[i] = '0;

    // power-on reset, asserted between edges
    #2 rst = 1'b0;
    #1;
    check_idle("por");
    chk("por_wr_err", 32'(wr_err), 32'd0);
    #10 rst = 1'b1;
    cycle();
    check_idle("idle_after_reset");

    // cleared image streams as all-zero beats
    run_load(1'b0, -1, -1, -1);

    // nominal image 0x0A5, 0x1A5, ...
    for (int i = 0; i < 8; i++) write_img(3'(i), 12'(32'h100 * i + 32'h0A5));
    run_load(1'b0, -1, -1, -1);

    // gpi forwarding in DONE, one cycle of latency
    gpi = 4'hA;
    cycle();
    chk("gpi_fwd_A", 32'(tgt_data), 32'h28);
    for (int k = 0; k < 4; k++) begin
      gpi = 4'($urandom);
      cycle();
      chk("gpi_fwd_rand", 32'(tgt_data), 32'({gpi, 2'b00}));
      chk("gpi_done_held", 32'(done), 32'd1);
    end

    // new data from DONE, restart with same-cycle write, blocked write, ignored start
    for (int k = 0; k < 3; k++) write_img(3'($urandom_range(0, 7)), 12'($urandom));
    run_load(1'b1, 4, 7, -1);
    chk("no_extra_wr_err", 32'(wr_err), 32'd0);

    // fully random image reloaded from DONE
    for (int i = 0; i < 8; i++) write_img(3'(i), 12'($urandom));
    run_load(1'b0, -1, -1, -1);

    // async reset at beat 9 abandons the load and clears the image
    run_load(1'b0, -1, -1, 9);
    for (int i = 0; i < 8; i++) exp_img[i] = '0;
    #1 rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check_idle("post_abort_idle");
    end
    run_load(1'b0, -1, -1, -1);

    // load straight from IDLE after fresh random image plus same-cycle write
    for (int i = 0; i < 8; i++) write_img(3'(i), 12'($urandom));
    gpi = 4'($urandom);
    run_load(1'b1, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_streamer.md
Name: rom_streamer

Overview:
- Host-side transmitter for the tinysoc instruction-ROM loader.
- Holds an 8 x 12-bit program image written by a host port.
- On a start command it holds the target in reset, then drives the image as sixteen 6-bit half-words on the target's io_in[7:2] lines: low half first, then high half.
- After the image is sent it forwards general-purpose inputs onto the same lines so the running target reads them on io_in[7:4].
- Shares the target's clock.

Parameters:
- RST_CYCLES, 2, number of cycles tgt_rst is held high before streaming (legal range 1..15)
- INSTR_WIDTH, 12, instruction width; half-word = INSTR_WIDTH/2 = 6
- DEPTH, 8, image entries; address width = 3

Ports:
- clk  in  1  clock, also the target clock
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  host image write strobe
- wr_addr  in  3  host image write address
- wr_data  in  12  host image write data
- start  in  1  single-cycle start pulse
- gpi  in  4  general-purpose input forwarded to target after load
- busy  out  1  high in RESET or STREAM state
- done  out  1  high in DONE state
- wr_err  out  1  one-cycle pulse when wr_en is seen while busy
- tgt_rst  out  1  target reset (target's io_in[1], active-high)
- tgt_data  out  6  target io_in[7:2]

Behaviour:
- Reset (rst=0, async): state=IDLE; all image entries=0; tgt_rst=1; tgt_data=0; busy=0; done=0; wr_err=0; counters=0.
- All outputs are registered.
- States: IDLE, RESET, STREAM, DONE.
- Image write: in IDLE or DONE, wr_en writes wr_data to image[wr_addr] at the clock edge. In RESET or STREAM the write is dropped and wr_err pulses on the next cycle.
- IDLE:
  - tgt_rst=1, tgt_data=0.
  - start -> RESET; cycle counter loads RST_CYCLES-1.
- RESET:
  - tgt_rst=1, tgt_data=0.
  - Counter decrements each cycle.
  - At count 0: the same edge registers tgt_rst<=0 and tgt_data<=image[0][5:0], beat counter=0, -> STREAM.
  - tgt_rst is therefore high for exactly RST_CYCLES cycles after the start edge.
- STREAM:
  - beat b (0..15) drives image[b>>1][5:0] when b even, image[b>>1][11:6] when b odd.
  - One beat per cycle, no gaps, so the target captures beat b on the edge after it is driven.
  - The edge that ends beat 15 -> DONE and registers tgt_data<={gpi,2'b00}.
- Beat ordering is fixed to match the target loader: even beat = low half latched, odd beat = write of {high, low} to address b>>1. Total 16 beats; the target sets rom_done on the edge ending beat 15.
- DONE:
  - tgt_rst=0.
  - tgt_data registered as {gpi, 2'b00} every cycle (one-cycle latency from gpi).
  - done=1.
- start while in DONE -> RESET (full reload; the target is re-reset).
- start while busy is ignored.
- start and wr_en in the same cycle from IDLE/DONE: the write occurs and is included in the stream, because image[0] is read at the end of RESET, never earlier.
- Image reads during STREAM use the live image. Writes are blocked while busy, so the image is stable.
- Async reset mid-stream: return to IDLE immediately with tgt_rst=1. A partial target load is abandoned, and the target is held in reset until the next start.
- busy = (state==RESET || state==STREAM); done = (state==DONE). Both are registered alongside the state.

Test Plan:
- Reset values: assert rst=0 mid-cycle -> outputs change asynchronously to tgt_rst=1, tgt_data=0, busy=0, done=0; image reads back 0 via a stream of all-zero beats.
- Nominal load:
  - write image[i]=12'h100*i+12'h0A5 (i=0..7), pulse start.
  - tgt_rst high exactly 2 cycles.
  - then 16 beats: 6'h25, 6'h02, 6'h25, 6'h06, ... (b0=0x0A5[5:0]=0x25, b1=0x0A5[11:6]=0x02; for i=1, 0x1A5 -> 0x25, 0x06).
  - done=1 on cycle 19 after the start edge.
- End-to-end: connect to a tinysoc instance. Program image[0]=12'h605 (imm 5->r0), image[1]=12'h400 (store r0 -> [r0]), image[2..7]=12'h800 (jump [r0]).
  - Streamed image matches: tgt_rst=1 during RESET, 16 beats, then done=1.
  - The target's rom_done rises on the edge ending beat 15.
  - Each target instruction-memory entry equals its image entry.
  - Target PC leaves 0 only after done.
- Protected writes: wr_en during STREAM beat 4 -> wr_err pulses once; image unchanged; streamed beats equal the pre-start image.
- Restart and ignored start: pulse start at beat 7 -> ignored, stream completes normally. Pulse start in DONE -> tgt_rst reasserted for 2 cycles and a full 16-beat reload follows.
- GPI forwarding: in DONE drive gpi=4'hA -> tgt_data=6'b101000 one cycle later. Mid-stream async reset at beat 9 -> IDLE, tgt_rst=1, done stays 0.
